instr_mem_resp: RTL
===================

# instr_mem_resp

Instruction-memory responder: the memory end of the instruction-fetch interface. Accepts word fetch requests from the fetch stage over a valid/ready handshake, reads a synchronous word-addressed instruction store with fixed latency, and returns in-order responses over a second valid/ready handshake with backpressure. A separate load port writes program words into the store. Sits between `instr_fetch` and the `core` instances in `SparCool`.

## Interface
- `DEPTH_WORDS`, 1024: instruction store depth in 32-bit words; power of two.
- `LATENCY`, 2: cycles from request acceptance to response visibility; legal range 1..4.
- `QDEPTH`, 4: maximum outstanding requests (pipeline + response buffer); must be ≥ `LATENCY`.

- `c`  in  1: clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: fetch request present.
- `req_ready`  out  1: responder can accept a request this cycle.
- `req_addr`  in  32: byte address (PC).
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: fetch stage consumes the response this cycle.
- `rsp_data`  out  32: instruction word; 0 when `rsp_err`=1.
- `rsp_err`  out  1: request misaligned or out of range.
- `load_en`  in  1: write one program word this cycle.
- `load_addr`  in  log2(DEPTH_WORDS): word index.
- `load_data`  in  32: word written.

## Operation
- Request accepted on a cycle with `req_valid && req_ready`. Response returned on a cycle with `rsp_valid && rsp_ready`.
- Word index = `req_addr[31:2]`. Error if `req_addr[1:0] != 0` or index ≥ `DEPTH_WORDS`; an error response still occupies a slot, stays in order, returns `rsp_data`=0, and has no store side effect.
- Outstanding counter `outst` (0..QDEPTH): +1 on accept, −1 on return, unchanged when both occur. `req_ready = (outst < QDEPTH)`, decoded from registered state only, with no combinational path from `rsp_ready`.
- Fixed-latency read pipeline of `LATENCY` stages. Each stage carries valid, data, and err. The final stage writes into the response FIFO (`QDEPTH` entries). The `outst` limit guarantees the FIFO never overflows, so the pipeline never stalls.
- `rsp_*` drive the FIFO head. `rsp_valid` = FIFO not empty. Responses are strictly in request order.
- Load port: write takes effect at the clock edge. A fetch reading the same word in the same cycle returns the old word (read-before-write). A load has priority over nothing else and is never blocked.
- Reset: clears `outst`, pipeline valids, and FIFO pointers. The store contents are not cleared. Any in-flight requests are discarded and no responses are produced for them.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0.
- `rst` sampled high on an edge: on the next cycle every output is at its reset value, regardless of traffic. Requests presented during `rst`=1 are not accepted.
- Latency: a request accepted in cycle T produces `rsp_valid`=1 in cycle T+LATENCY, provided earlier responses have drained.
- Throughput: 1 request and 1 response per cycle sustained when `rsp_ready`=1.
- Backpressure: with `rsp_ready`=0, `rsp_valid`/`rsp_data`/`rsp_err` hold stable until the handshake. After `QDEPTH` accepts without returns, `req_ready`=0 from the next cycle. A return in cycle X raises `req_ready` in cycle X+1.
- Boundary conditions:
  - FIFO full and a pop in the same cycle as a push: legal, and the entry count is unchanged.
  - FIFO empty and a pipeline write: the response is visible the next cycle, with no bypass.

## Structure
- Shared `sparcool_pkg`:
  - `WORDSIZE`=4 and `BITNESS`=32.
  - The response struct {err, data[31:0]}.
  - An `addr_to_word` helper.
- Sub-module `resp_fifo`: synchronous FIFO with parameterised depth and width, and full/empty flags derived from pointers carrying an extra wrap bit.
- The store is a single inferred synchronous RAM with one read port and one write port.

## Test plan
- Preload words 0..3 = 0x11111111..0x44444444, hold `rsp_ready`=1, request addresses 0x0, 0x4, 0x8, 0xC back-to-back → responses 0x11111111..0x44444444 in cycles 2..5, `rsp_err`=0.
- Request 0x6 then 0x1000 (`DEPTH_WORDS`=1024) → two responses in order with `rsp_err`=1 and `rsp_data`=0. A following request to 0x0 → 0x11111111 with err=0.
- Hold `rsp_ready`=0 and issue 6 requests → exactly 4 accepted and `req_ready`=0 from the cycle after the 4th. Raise `rsp_ready` → the 4 responses return in order and `req_ready`=1 one cycle after the first return.
- Same-cycle load of word 2 = 0xDEADBEEF and fetch of 0x8 → old word 0x33333333. The next fetch of 0x8 → 0xDEADBEEF.
- Assert `rst` for one cycle with 3 requests in flight → `rsp_valid`=0 and `req_ready`=1 the next cycle, and no stale responses ever appear. The store still returns 0x11111111 for 0x0.
- Random valid/ready toggling over 10k cycles → scoreboard shows in-order, lossless, duplicate-free responses and no FIFO overflow.

Source files
------------

// File: rtl/sparcool_pkg.sv
// Shared definitions for the SparCool fetch path: word geometry, the
// instruction response payload and the byte-address to word-index helper.
package sparcool_pkg;

  localparam int unsigned WORDSIZE = 4;
  localparam int unsigned BITNESS  = 32;
  localparam int unsigned WORDBITS = BITNESS - 2;

  // One returned instruction: err flags a misaligned/out-of-range fetch.
  typedef struct packed {
    logic               err;
    logic [BITNESS-1:0] data;
  } rsp_t;

  // Word index of a byte address (drops the byte offset within a 4-byte word).
  function automatic logic [WORDBITS-1:0] addr_to_word(input logic [BITNESS-1:0] addr);
    return addr[BITNESS-1:2];
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO for fetch responses. Pointers carry an extra wrap bit so
// full and empty come straight from pointer compares. DEPTH: power of two, >= 2.
// Ports: clk_i, rst_i (sync, active high), push_i/wdata_i (write side),
//        pop_i/rdata_o (read side, rdata_o shows the head), empty_o.
module resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the head slot in the same cycle, so full+pop+push is legal.
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage (not reset; validity comes from the pointers)
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/instr_mem_resp.sv
// Instruction-memory responder. Accepts word fetches (valid/ready), reads a
// synchronous word-addressed store with fixed latency and returns in-order
// responses (valid/ready with backpressure). A load port writes program words.
// Ports: c (clock), rst (sync, active high),
//        req_valid/req_ready/req_addr   fetch request, byte address,
//        rsp_valid/rsp_ready/rsp_data/rsp_err  response, data 0 on error,
//        load_en/load_addr/load_data    program-word write port.
module instr_mem_resp
  import sparcool_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned QDEPTH      = 4
) (
  input  logic                           c,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_data,
  output logic                           rsp_err,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [CW-1:0]       outst_q, outst_d;
  logic                accept, ret, req_err;
  logic [WORDBITS-1:0] word;
  logic [AW-1:0]       ridx;
  logic [31:0]         store_q [DEPTH_WORDS];
  logic                push, fifo_empty;
  rsp_t                push_rsp, head;

  assign word    = addr_to_word(req_addr);
  assign ridx    = word[AW-1:0];
  assign req_err = (req_addr[1:0] != 2'b00) || (word >= WORDBITS'(DEPTH_WORDS));

  // Ready depends on registered occupancy only; no path from rsp_ready.
  assign req_ready = (outst_q < CW'(QDEPTH));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = !fifo_empty;
  assign ret       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? head.data : 32'h0;
  assign rsp_err   = rsp_valid && head.err;

  // Outstanding count: pipeline plus response buffer
  always_comb begin
    outst_d = outst_q;
    case ({accept, ret})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) outst_q <= '0;
    else     outst_q <= outst_d;
  end

  // Program load; a same-cycle fetch of this word sees the old value.
  always_ff @(posedge c) begin
    if (load_en) store_q[load_addr] <= load_data;
  end

  if (LATENCY == 1) begin : g_lat1
    // The buffer register itself supplies the one cycle of latency.
    assign push     = accept;
    assign push_rsp = {req_err, (req_err ? 32'h0 : store_q[ridx])};
  end else begin : g_pipe
    logic [LATENCY-1:1] vld_q, err_q;
    logic [31:0]        dat_q [1:LATENCY-1];

    // Stage control; cleared by reset so in-flight fetches vanish.
    always_ff @(posedge c) begin
      if (rst) begin
        vld_q <= '0;
        err_q <= '0;
      end else begin
        vld_q[1] <= accept;
        err_q[1] <= accept && req_err;
        for (int k = 2; k < int'(LATENCY); k++) begin
          vld_q[k] <= vld_q[k-1];
          err_q[k] <= err_q[k-1];
        end
      end
    end

    // Stage 1 is the RAM read register; later stages just delay it.
    always_ff @(posedge c) begin
      dat_q[1] <= store_q[ridx];
      for (int k = 2; k < int'(LATENCY); k++) dat_q[k] <= dat_q[k-1];
    end

    assign push     = vld_q[LATENCY-1];
    assign push_rsp = {err_q[LATENCY-1], (err_q[LATENCY-1] ? 32'h0 : dat_q[LATENCY-1])};
  end

  // Never overflows: outst_q caps pipeline plus buffer at QDEPTH.
  resp_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(rsp_t))
  ) u_fifo (
    .clk_i   (c),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i (push_rsp),
    .pop_i   (ret),
    .rdata_o (head),
    .empty_o (fifo_empty)
  );

endmodule
